seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The module SHALL have parameter NDIG, default 8, giving the number of digits (legal range 2..8).
REQ-002 The module SHALL have parameter DIV, default 100, giving the scan-tick period in CLK cycles (legal minimum 2).
REQ-003 The module SHALL have parameter LZS, default 0, where 1 enables leading-zero suppression.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 The module SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port HEX_IN, input, 4*NDIG bits: nibble k is the code for digit k.
REQ-007 The module SHALL have port DISP_EN, input, NDIG bits: per-digit enable.
REQ-008 The module SHALL have port DP_IN, input, NDIG bits: per-digit decimal point, active-high.
REQ-009 The module SHALL have port BRIGHT, input, 4 bits: brightness level 0..15.
REQ-010 The module SHALL have port LOAD, input, 1 bit: a one-cycle strobe that samples HEX_IN, DISP_EN and DP_IN.
REQ-011 The module SHALL have port SEG, output, 7 bits: segment drives, active-low, bit0=CA through bit6=CG.
REQ-012 The module SHALL have port DP, output, 1 bit: decimal-point drive, active-low.
REQ-013 The module SHALL have port AN, output, NDIG bits: anode drives, active-low.
REQ-014 The module SHALL have port UPD_PEND, output, 1 bit: high while a staged update awaits a frame boundary.
REQ-015 The module SHALL have port FRAME_SYNC, output, 1 bit: a one-cycle pulse after each frame boundary.

Function
REQ-016 The prescaler SHALL count 0..DIV-1 and wrap to 0; TICK SHALL be true in the cycle the count equals DIV-1.
REQ-017 On each TICK, a 4-bit sub-slot counter SUB SHALL increment 0..15 and wrap; when SUB wraps 15->0, digit index DIG SHALL increment 0..NDIG-1 and wrap.
REQ-018 Consequently, each digit slot SHALL last 16*DIV clocks and each frame SHALL last NDIG*16*DIV clocks.
REQ-019 A frame boundary SHALL be defined as the edge where TICK, SUB==15 and DIG==NDIG-1 all hold.
REQ-020 LOAD=1 SHALL capture HEX_IN, DISP_EN and DP_IN into staging registers and set UPD_PEND on the same edge; a repeat LOAD SHALL overwrite the staging registers (last wins).
REQ-021 At a frame boundary with UPD_PEND=1, the staging registers SHALL be copied into the active registers and UPD_PEND SHALL clear.
REQ-022 If LOAD coincides with a frame boundary, the pre-edge staging contents SHALL transfer to the active registers, the new data SHALL enter staging, and UPD_PEND SHALL remain 1.
REQ-023 Active registers SHALL change only at frame boundaries, so no frame ever mixes old and new data.
REQ-024 The digit decoder SHALL map hex 0..F to standard segment patterns (0..9, A, b, C, d, E, F), identical to the existing SevenSegDec encoding.
REQ-025 A digit SHALL be lit when its active enable bit is 1, it is not zero-suppressed, and SUB < BRIGHT.
REQ-026 BRIGHT=0 SHALL leave all digits dark; BRIGHT=15 SHALL give a 15/16 duty cycle; BRIGHT changes SHALL take effect without waiting for a frame boundary.
REQ-027 With LZS=1, digit k (k >= 1) SHALL be suppressed when its code and all active codes above it are 0; digit 0 SHALL never be suppressed.
REQ-028 With LZS=1, disabled digits SHALL count as zero for the suppression test.
REQ-029 SEG, DP and AN SHALL be registered, with exactly one cycle of latency from the DIG/SUB state.
REQ-030 Only AN[DIG] SHALL ever be low, and only when the digit is lit.
REQ-031 When no digit is lit, SEG and DP SHALL still show the current digit's pattern while all AN bits are 1.
REQ-032 DP SHALL be the inverse of active DP_IN[DIG].
REQ-033 FRAME_SYNC SHALL be high for exactly the one cycle following each frame boundary, regardless of UPD_PEND.

Reset
REQ-034 While RST_N=0, the prescaler, SUB and DIG SHALL be 0, the staging and active registers SHALL be 0, UPD_PEND=0 and FRAME_SYNC=0.
REQ-035 While RST_N=0, SEG=7'h7F, DP=1 and AN=all ones, applied immediately and asynchronously.
REQ-036 Reset asserted mid-frame SHALL discard any pending update; scanning SHALL restart at DIG=0, SUB=0 on the first edge after RST_N rises.

Verification (NDIG=4, DIV=2, LZS=0 unless stated)
REQ-037 Reset release, LOAD HEX_IN=16'h1234, DISP_EN=4'hF, BRIGHT=15 -> data goes active at the first boundary (clock 128); AN then cycles 1110, 1101, 1011, 0111 at 32-clock slots, each low for 30 of 32 clocks, with SEG matching 4, 3, 2, 1.
REQ-038 BRIGHT=4 -> each anode low for exactly 8 clocks per 32-clock slot; BRIGHT=0 -> AN stays 4'hF for a full frame.
REQ-039 Two LOADs mid-frame (16'hAAAA, then 16'h5555), plus a LOAD on the boundary edge -> active data becomes 16'h5555 and UPD_PEND stays 1 until the next boundary.
REQ-040 LZS=1, HEX_IN=16'h0070 -> digits 3 and 2 are dark, digit 1 shows 7, digit 0 shows 0; HEX_IN=16'h0000 -> only digit 0 is lit.
REQ-041 DP_IN=4'b0100 -> DP low only during digit 2's slot.
REQ-042 RST_N pulsed low during digit 2 with UPD_PEND=1 -> outputs are idle immediately, UPD_PEND=0, and the active data is 0 after release.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display
// updates, PWM brightness via 16 sub-slots per digit, and optional
// leading-zero suppression.
module seg_scan_driver #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 100,
  parameter int unsigned LZS  = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4*NDIG-1:0] HEX_IN,
  input  logic [NDIG-1:0]   DISP_EN,
  input  logic [NDIG-1:0]   DP_IN,
  input  logic [3:0]        BRIGHT,
  input  logic              LOAD,
  output logic [6:0]        SEG,
  output logic              DP,
  output logic [NDIG-1:0]   AN,
  output logic              UPD_PEND,
  output logic              FRAME_SYNC
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned DW = $clog2(NDIG);

  logic [PW-1:0]     r_pre;
  logic [3:0]        r_sub;
  logic [DW-1:0]     r_dig;
  logic [4*NDIG-1:0] r_stg_hex, r_act_hex;
  logic [NDIG-1:0]   r_stg_en, r_act_en, r_stg_dp, r_act_dp;
  logic              r_upd_pend;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [NDIG-1:0]   r_an;
  logic              r_fsync;

  logic       w_tick, w_bnd, w_supp, w_above_zero, w_lit;
  logic [3:0] w_code;
  logic [6:0] w_seg;

  assign w_tick = (r_pre == PW'(DIV - 1));
  assign w_bnd  = w_tick && (r_sub == 4'hF) && (r_dig == DW'(NDIG - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= '0;
      r_sub <= '0;
      r_dig <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        r_sub <= r_sub + 4'd1;
        if (r_sub == 4'hF)
          r_dig <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + DW'(1);
      end
    end
  end

  // Active data moves only at a frame boundary, and always from the pre-edge
  // staging contents, so a LOAD on the boundary edge lands in staging.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stg_hex  <= '0;
      r_stg_en   <= '0;
      r_stg_dp   <= '0;
      r_act_hex  <= '0;
      r_act_en   <= '0;
      r_act_dp   <= '0;
      r_upd_pend <= 1'b0;
    end else begin
      if (w_bnd && r_upd_pend) begin
        r_act_hex <= r_stg_hex;
        r_act_en  <= r_stg_en;
        r_act_dp  <= r_stg_dp;
      end
      if (LOAD) begin
        r_stg_hex  <= HEX_IN;
        r_stg_en   <= DISP_EN;
        r_stg_dp   <= DP_IN;
        r_upd_pend <= 1'b1;
      end else if (w_bnd) begin
        r_upd_pend <= 1'b0;
      end
    end
  end

  assign w_code = r_act_hex[4*r_dig +: 4];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_seg = 7'h7F;
    case (w_code)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  // Walk down from the top digit; a digit is blank while it and everything
  // above it is zero or disabled. Digit 0 is never visited.
  always_comb begin
    w_above_zero = 1'b1;
    w_supp       = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      w_above_zero = w_above_zero & (!r_act_en[k] | (r_act_hex[4*k +: 4] == 4'h0));
      if (r_dig == DW'(k))
        w_supp = w_above_zero;
    end
  end

  assign w_lit = r_act_en[r_dig] && !((LZS != 0) && w_supp) && (r_sub < BRIGHT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_an    <= '1;
      r_fsync <= 1'b0;
    end else begin
      r_seg   <= w_seg;
      r_dp    <= ~r_act_dp[r_dig];
      r_an    <= w_lit ? ~(NDIG'(1) << r_dig) : '1;
      r_fsync <= w_bnd;
    end
  end

  assign SEG        = r_seg;
  assign DP         = r_dp;
  assign AN         = r_an;
  assign UPD_PEND   = r_upd_pend;
  assign FRAME_SYNC = r_fsync;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-count based reference model checked every
// cycle, directed frame measurements, and a randomized LOAD/BRIGHT phase.
module tb_seg_scan_driver;

  localparam int NDIG  = 4;
  localparam int DIV   = 2;
  localparam int FRAME = NDIG * 16 * DIV;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] HEX_IN;
  logic [3:0]  DISP_EN, DP_IN, BRIGHT;
  logic        LOAD;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, pend_a, pend_b, fs_a, fs_b;
  logic [3:0] an_a, an_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  seg_scan_driver #(.NDIG(NDIG), .DIV(DIV), .LZS(0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .HEX_IN(HEX_IN), .DISP_EN(DISP_EN), .DP_IN(DP_IN),
    .BRIGHT(BRIGHT), .LOAD(LOAD), .SEG(seg_a), .DP(dp_a), .AN(an_a),
    .UPD_PEND(pend_a), .FRAME_SYNC(fs_a)
  );

  seg_scan_driver #(.NDIG(NDIG), .DIV(DIV), .LZS(1)) u_dut_lzs (
    .CLK(CLK), .RST_N(RST_N), .HEX_IN(HEX_IN), .DISP_EN(DISP_EN), .DP_IN(DP_IN),
    .BRIGHT(BRIGHT), .LOAD(LOAD), .SEG(seg_b), .DP(dp_b), .AN(an_b),
    .UPD_PEND(pend_b), .FRAME_SYNC(fs_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard active-high gfedcba patterns; the driver outputs their inverse.
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic lit(input int lzs, input int dig, input int sub,
                               input logic [15:0] hx, input logic [3:0] en,
                               input logic [3:0] br);
    bit blank = 0;
    if (lzs != 0 && dig >= 1) begin
      blank = 1;
      for (int k = dig; k < NDIG; k++)
        if (en[k] && hx[4*k +: 4] != 4'h0) blank = 0;
    end
    return en[dig] && !blank && (sub < int'(br));
  endfunction

  // Reference model: position in the scan is pure arithmetic on edges since reset.
  int          m_e, m_sub, m_dig;
  bit          m_bnd, m_pend;
  logic [15:0] m_act_hex, m_stg_hex;
  logic [3:0]  m_act_en, m_stg_en, m_act_dp, m_stg_dp;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_pend, exp_fs;
  logic [3:0]  exp_an_a, exp_an_b;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_e = 0; m_pend = 0;
      m_act_hex = '0; m_stg_hex = '0; m_act_en = '0; m_stg_en = '0;
      m_act_dp = '0; m_stg_dp = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an_a = 4'hF; exp_an_b = 4'hF;
      exp_pend = 1'b0; exp_fs = 1'b0;
    end else begin
      m_sub = (m_e / DIV) % 16;
      m_dig = (m_e / (16 * DIV)) % NDIG;
      m_bnd = ((m_e + 1) % FRAME) == 0;
      exp_seg  = ~pat[m_act_hex[4*m_dig +: 4]];
      exp_dp   = ~m_act_dp[m_dig];
      exp_an_a = lit(0, m_dig, m_sub, m_act_hex, m_act_en, BRIGHT) ? ~(4'b0001 << m_dig) : 4'hF;
      exp_an_b = lit(1, m_dig, m_sub, m_act_hex, m_act_en, BRIGHT) ? ~(4'b0001 << m_dig) : 4'hF;
      exp_fs   = m_bnd;
      if (m_bnd && m_pend) begin
        m_act_hex = m_stg_hex; m_act_en = m_stg_en; m_act_dp = m_stg_dp;
        m_pend = 0;
      end
      if (LOAD) begin
        m_stg_hex = HEX_IN; m_stg_en = DISP_EN; m_stg_dp = DP_IN;
        m_pend = 1;
      end
      exp_pend = m_pend;
      m_e++;
    end
  end

  always @(negedge CLK) begin
    if (RST_N) begin
      check("out_lzs0", {seg_a, dp_a, an_a, pend_a, fs_a},
            {exp_seg, exp_dp, exp_an_a, exp_pend, exp_fs});
      check("out_lzs1", {seg_b, dp_b, an_b, pend_b, fs_b},
            {exp_seg, exp_dp, exp_an_b, exp_pend, exp_fs});
    end
  end

  int         cnt_a [4], cnt_b [4], dpc [4];
  logic [6:0] fseg_a [4], fseg_b [4];

  task automatic load(input logic [15:0] h, input logic [3:0] en, input logic [3:0] d);
    @(posedge CLK); #1;
    HEX_IN = h; DISP_EN = en; DP_IN = d; LOAD = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
  endtask

  task automatic set_bright(input logic [3:0] b);
    @(posedge CLK); #1;
    BRIGHT = b;
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (fs_a) break;
    end
    check("frame_sync_seen", fs_a, 1);
  endtask

  // Call right at a FRAME_SYNC negedge: samples the 128 cycles of the next frame.
  task automatic count_frame();
    for (int k = 0; k < 4; k++) begin
      cnt_a[k] = 0; cnt_b[k] = 0; dpc[k] = 0; fseg_a[k] = 7'h7F; fseg_b[k] = 7'h7F;
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        if (!an_a[k]) begin
          if (cnt_a[k] == 0) fseg_a[k] = seg_a;
          cnt_a[k]++;
        end
        if (!an_b[k]) begin
          if (cnt_b[k] == 0) fseg_b[k] = seg_b;
          cnt_b[k]++;
        end
      end
      if (!dp_a) dpc[i / (16 * DIV)]++;
    end
  endtask

  logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; HEX_IN = '0; DISP_EN = '0; DP_IN = '0; BRIGHT = '0; LOAD = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_seg", seg_a, 7'h7F);
    check("rst_dp", dp_a, 1);
    check("rst_an", an_a, 4'hF);
    check("rst_pend", pend_a, 0);
    check("rst_fs", fs_a, 0);
    RST_N = 1'b1;

    // Basic scan at full brightness.
    BRIGHT = 4'd15;
    load(16'h1234, 4'hF, 4'h0);
    check("pend_after_load", pend_a, 1);
    wait_fs();
    count_frame();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lit15_dig%0d", k), cnt_a[k], 30);
      check($sformatf("seg1234_dig%0d", k), fseg_a[k], seg1234[k]);
    end

    set_bright(4'd4);
    wait_fs();
    count_frame();
    for (int k = 0; k < 4; k++) check($sformatf("lit4_dig%0d", k), cnt_a[k], 8);

    set_bright(4'd0);
    wait_fs();
    count_frame();
    for (int k = 0; k < 4; k++) check($sformatf("lit0_dig%0d", k), cnt_a[k], 0);

    // Last-wins staging plus a LOAD coinciding with the boundary edge.
    set_bright(4'd15);
    wait_fs();
    load(16'hAAAA, 4'hF, 4'h0);
    repeat (30) @(posedge CLK);
    load(16'h5555, 4'hF, 4'h0);
    repeat (FRAME - 34 - 1) @(posedge CLK);
    #1;
    HEX_IN = 16'h9876; LOAD = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    @(negedge CLK);
    check("fs_on_boundary", fs_a, 1);
    check("pend_kept", pend_a, 1);
    @(negedge CLK);
    check("act5555_seg", seg_a, 7'h12);
    check("act5555_an", an_a, 4'hE);
    wait_fs();
    check("pend_cleared", pend_a, 0);
    @(negedge CLK);
    check("act9876_seg", seg_a, 7'h02);

    // Leading-zero suppression and decimal point.
    load(16'h0070, 4'hF, 4'b0100);
    wait_fs();
    count_frame();
    check("lzs_dig0", cnt_b[0], 30);
    check("lzs_dig1", cnt_b[1], 30);
    check("lzs_dig2", cnt_b[2], 0);
    check("lzs_dig3", cnt_b[3], 0);
    check("nolzs_dig3", cnt_a[3], 30);
    check("lzs_seg7", fseg_b[1], 7'h78);
    check("lzs_seg0", fseg_b[0], 7'h40);
    check("dp_dig2", dpc[2], 32);
    check("dp_others", dpc[0] + dpc[1] + dpc[3], 0);
    load(16'h0000, 4'hF, 4'h0);
    wait_fs();
    count_frame();
    check("lzs_zero_dig0", cnt_b[0], 30);
    check("lzs_zero_rest", cnt_b[1] + cnt_b[2] + cnt_b[3], 0);

    // Reset during digit 2 with an update pending.
    wait_fs();
    load(16'hABCD, 4'hF, 4'hF);
    check("pend_before_rst", pend_a, 1);
    repeat (70) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_seg", seg_a, 7'h7F);
    check("async_rst_dp", dp_a, 1);
    check("async_rst_an", an_a, 4'hF);
    check("async_rst_pend", pend_a, 0);
    #10;
    RST_N = 1'b1;
    repeat (200) @(posedge CLK);
    @(negedge CLK);
    check("post_rst_seg", seg_a, 7'h40);
    check("post_rst_an", an_a, 4'hF);

    // Randomized LOAD / BRIGHT traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      if ($urandom_range(0, 39) == 0) begin
        HEX_IN  = 16'($urandom);
        DISP_EN = 4'($urandom);
        DP_IN   = 4'($urandom);
        LOAD    = 1'b1;
      end else begin
        LOAD = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) BRIGHT = 4'($urandom);
    end
    LOAD = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
